// File: rtl/drive_frame_scheduler.sv
// Servo frame scheduler: arbitrates nav/override commands into a one-entry slot, hands the slot to
// the modulator only on duty-pattern wrap, and generates the registered PWM line.
// Optional frame watchdog enabled by defining SCHED_WATCHDOG_EN.
module drive_frame_scheduler #(
  parameter int unsigned CLK_RATE      = 100_000_000,
  parameter int unsigned FRAME_CYCLES  = CLK_RATE / 50,
  parameter int unsigned STATE_WRAP    = 24,
  parameter int unsigned PULSE_MIN     = 100_000,
  parameter int unsigned PULSE_MAX     = 200_000,
  parameter int unsigned PULSE_NEUTRAL = 150_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        NavReq,
  input  logic [4:0]  NavModInfo,
  output logic        NavAck,
  input  logic        OvrReq,
  input  logic [4:0]  OvrModInfo,
  output logic        OvrAck,
  input  logic [20:0] Pulse,
  output logic [4:0]  ModInfo,
  output logic [4:0]  State,
  output logic        ServoOut,
  output logic        FrameStart
);

  localparam int unsigned FW = ($clog2(FRAME_CYCLES) > 21) ? $clog2(FRAME_CYCLES) : 21;
  localparam logic [FW-1:0] FLast    = FW'(FRAME_CYCLES - 1);
  localparam logic [FW-1:0] FLatch   = FW'(FRAME_CYCLES - 2);
  localparam logic [FW-1:0] FAdvance = FW'(FRAME_CYCLES - 4);
  localparam logic [4:0]    StLast   = 5'(STATE_WRAP - 1);
  localparam logic [20:0]   WMin     = 21'(PULSE_MIN);
  localparam logic [20:0]   WMax     = 21'(PULSE_MAX);
  localparam logic [20:0]   WNeutral = 21'(PULSE_NEUTRAL);
  localparam logic [4:0]    CmdNeutral = 5'b00001;

  logic [FW-1:0] f_q, f_d;
  logic [4:0]    state_q, state_d;
  logic [4:0]    mod_q, mod_d;
  logic [20:0]   w_q, w_d;
  logic          slot_vld_q, slot_vld_d;
  logic          slot_ovr_q, slot_ovr_d;
  logic [4:0]    slot_cmd_q, slot_cmd_d;
  logic          servo_q, servo_d;
  logic          frame_start_q, frame_start_d;
  logic          nav_ack_q, ovr_ack_q;
  logic          advance, wrap, nav_acc, ovr_acc, pulse_ok;

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned WdogFrames = 50;
  localparam int unsigned WdogW      = $clog2(WdogFrames + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             wdog_expired;
  assign wdog_expired = (wdog_q == WdogW'(WdogFrames));
`endif

  always_comb begin
    advance = (f_q == FAdvance);
    wrap    = advance && (state_q == StLast);
    // The wrap cycle belongs to the slot hand-off; requests seen there wait one cycle.
    ovr_acc = OvrReq && !(slot_vld_q && slot_ovr_q) && !wrap;
    nav_acc = NavReq && !OvrReq && !slot_vld_q && !wrap;

    f_d     = (f_q == FLast) ? '0 : f_q + 1'b1;
    state_d = state_q;
    if (advance) state_d = wrap ? 5'd0 : state_q + 5'd1;

    pulse_ok = (Pulse >= WMin) && (Pulse <= WMax);
    w_d      = w_q;
    if (f_q == FLatch) w_d = pulse_ok ? Pulse : WNeutral;

    servo_d       = (f_q < FW'(w_q));
    frame_start_d = (f_q == '0);

    slot_vld_d = slot_vld_q;
    slot_ovr_d = slot_ovr_q;
    slot_cmd_d = slot_cmd_q;
    mod_d      = mod_q;
    if (wrap && slot_vld_q) begin
      mod_d      = slot_cmd_q;
      slot_vld_d = 1'b0;
    end
`ifdef SCHED_WATCHDOG_EN
    else if (wrap && wdog_expired) begin
      mod_d = CmdNeutral;
    end
`endif
    if (ovr_acc) begin
      slot_vld_d = 1'b1;
      slot_ovr_d = 1'b1;
      slot_cmd_d = OvrModInfo;
    end else if (nav_acc) begin
      slot_vld_d = 1'b1;
      slot_ovr_d = 1'b0;
      slot_cmd_d = NavModInfo;
    end

`ifdef SCHED_WATCHDOG_EN
    wdog_d = wdog_q;
    if (ovr_acc || nav_acc) wdog_d = '0;
    else if ((f_q == FLast) && !wdog_expired) wdog_d = wdog_q + 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      f_q           <= '0;
      state_q       <= '0;
      mod_q         <= CmdNeutral;
      w_q           <= WNeutral;
      slot_vld_q    <= 1'b0;
      slot_ovr_q    <= 1'b0;
      slot_cmd_q    <= '0;
      servo_q       <= 1'b0;
      frame_start_q <= 1'b0;
      nav_ack_q     <= 1'b0;
      ovr_ack_q     <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      wdog_q        <= '0;
`endif
    end else begin
      f_q           <= f_d;
      state_q       <= state_d;
      mod_q         <= mod_d;
      w_q           <= w_d;
      slot_vld_q    <= slot_vld_d;
      slot_ovr_q    <= slot_ovr_d;
      slot_cmd_q    <= slot_cmd_d;
      servo_q       <= servo_d;
      frame_start_q <= frame_start_d;
      nav_ack_q     <= nav_acc;
      ovr_ack_q     <= ovr_acc;
`ifdef SCHED_WATCHDOG_EN
      wdog_q        <= wdog_d;
`endif
    end
  end

  assign NavAck     = nav_ack_q;
  assign OvrAck     = ovr_ack_q;
  assign ModInfo    = mod_q;
  assign State      = state_q;
  assign ServoOut   = servo_q;
  assign FrameStart = frame_start_q;

endmodule

// File: doc/drive_frame_scheduler.md
DRIVE_FRAME_SCHEDULER -- requirements
Module: drive_frame_scheduler

Interface
REQ-001 SHALL have parameter CLK_RATE, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter FRAME_CYCLES, default CLK_RATE/50 (2,000,000), servo frame length in clocks (20 ms).
REQ-003 SHALL have parameter STATE_WRAP, default 24, number of frames per duty-pattern cycle.
REQ-004 SHALL use one clock and a synchronous, active-high reset: CLK input 1 bit, rising-edge system clock; RST input 1 bit, synchronous, active-high reset.
REQ-005 SHALL have port NavReq, input, 1 bit, navigation command request, held until acked.
REQ-006 SHALL have port NavModInfo, input, 5 bits, navigation command: [4:2] power code, [1:0] direction.
REQ-007 SHALL have port NavAck, output, 1 bit, one-cycle accept pulse for NavReq.
REQ-008 SHALL have port OvrReq, input, 1 bit, override (manual/safety) command request, held until acked.
REQ-009 SHALL have port OvrModInfo, input, 5 bits, override command, same encoding as NavModInfo.
REQ-010 SHALL have port OvrAck, output, 1 bit, one-cycle accept pulse for OvrReq.
REQ-011 SHALL have port Pulse, input, 21 bits, high-time in clocks returned by the pulse modulator.
REQ-012 SHALL have port ModInfo, output, 5 bits, active command driven to the pulse modulator.
REQ-013 SHALL have port State, output, 5 bits, frame index 0..STATE_WRAP-1 driven to the pulse modulator.
REQ-014 SHALL have port ServoOut, output, 1 bit, PWM line to the ESC.
REQ-015 SHALL have port FrameStart, output, 1 bit, one-cycle pulse when frame counter F = 0.

Function
REQ-016 SHALL run frame counter F from 0 to FRAME_CYCLES-1, wrapping to 0.
REQ-017 SHALL advance State at F = FRAME_CYCLES-4, wrapping from STATE_WRAP-1 to 0.
REQ-018 SHALL hold a single-entry pending slot; a command is accepted only into the slot, and Ack asserts in the cycle after the accepting edge.
REQ-019 SHALL accept NavReq only when the slot is empty and OvrReq is low.
REQ-020 SHALL accept OvrReq whenever asserted, including when the slot holds a nav command (the nav command is discarded), giving override priority on simultaneous requests.
REQ-021 SHALL NOT let an override overwrite a pending override; OvrReq then waits until the slot empties.
REQ-022 SHALL copy the slot to ModInfo and empty the slot only in the cycle State advances STATE_WRAP-1 to 0, so a duty pattern is never torn.
REQ-023 SHALL accept into the slot a request arriving in that same transfer cycle only on the following cycle.
REQ-024 SHALL latch width W from Pulse at F = FRAME_CYCLES-2, covering the modulator's one-cycle registered latency.
REQ-025 SHALL clamp W: any Pulse value below 100000 or above 200000 latches 150000 (neutral).
REQ-026 SHALL drive ServoOut high while F < W and low otherwise, registered.

Reset
REQ-027 SHALL, on RST high at a clock edge, set: F = 0; State = 0; ModInfo = 5'b00001 (power 0, neutral); W = 150000; slot empty; ServoOut, FrameStart, NavAck and OvrAck = 0; watchdog count = 0.
REQ-028 SHALL, on RST asserted mid-frame or mid-handshake, discard the pending command without an ack; the requester re-requests.
REQ-029 SHALL, on the first edge after RST deasserts, have F = 1, FrameStart = 1 and ServoOut = 1, per REQ-015 and REQ-026.

Configuration
REQ-030 SHALL, with SCHED_WATCHDOG_EN defined, count frames since the last accepted command and, after 50 frames, force ModInfo to 5'b00001 at the next State wrap; any accept clears the count.
REQ-031 SHALL, without SCHED_WATCHDOG_EN, omit the watchdog logic; ModInfo holds its last value indefinitely.

Verification
REQ-032 SHALL cover: reset, then no requests -> ServoOut high 150000 clocks every 2,000,000 clocks; State 0->1 at F = 1,999,996.
REQ-033 SHALL cover: NavReq = 1 and OvrReq = 1 in the same cycle, NavModInfo = 5'b11100, OvrModInfo = 5'b00001 -> OvrAck pulses, NavAck stays 0, ModInfo = 5'b00001 after the next State wrap.
REQ-034 SHALL cover: nav 5'b11100 accepted at State = 5 -> ModInfo unchanged until State 23->0, then 5'b11100.
REQ-035 SHALL cover: Pulse forced to 250000 -> ServoOut high for exactly 150000 clocks in the next frame.
REQ-036 SHALL cover: with SCHED_WATCHDOG_EN, nav 5'b11100 accepted, then 50 frames with no requests -> ModInfo = 5'b00001 at the following wrap; without the macro, ModInfo stays 5'b11100.
REQ-037 SHALL cover: RST pulsed while the slot is full -> no ack, ModInfo = 5'b00001, F = 0.
